// File: rtl/lab3_2_display_scan.sv
// lab3_2_display_scan
// Purpose: consumer of the lab3_2 result interface. It drives a 4-digit
//   multiplexed 7-segment display.
//   - A load strobe captures the result into a pending register.
//   - The pending value is committed tear-free at frame boundaries.
//   - One digit is scanned per slot, and each nibble is hex-decoded.
//   - While warning is set, the digit pair (slots 2 and 3) blinks.
// Ports:
//   CLK         in   1  clock, all logic on posedge
//   clear       in   1  synchronous reset, active-high
//   digit1      in   8  result digit 1 (bits [3:0] used)
//   digit0      in   8  result digit 0 (bits [3:0] used)
//   count1      in   8  mode-1 counter (bits [3:0] used)
//   count0      in   8  mode-0 counter (bits [3:0] used)
//   warning     in   1  invalid-input flag from the core
//   load        in   1  1-cycle strobe that samples the five inputs above
//   an          out  4  anode select, one-hot active-low, an[0] = rightmost
//   seg         out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp          out  1  decimal point, same polarity as seg
//   frame_done  out  1  1-cycle pulse after the last slot of a frame
// Optional feature: macro LEADING_ZERO_BLANK_EN blanks a leading zero in
//   slot 1 (count pair) and in slot 3 (digit pair).
module lab3_2_display_scan #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned BLINK_DIV      = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       clear,
    input  logic [7:0] digit1,
    input  logic [7:0] digit0,
    input  logic [7:0] count1,
    input  logic [7:0] count0,
    input  logic       warning,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] c1;
        logic [3:0] c0;
        logic       warn;
    } disp_t;

    disp_t            pending;
    disp_t            display;
    logic             pend_flag;
    logic [DIV_W-1:0] div;
    logic [1:0]       slot;
    logic [FRM_W-1:0] frame;
    logic             phase;

    disp_t      live_c;
    logic       boundary_c;
    logic [3:0] nib_c;
    logic [6:0] seg_hi_c;
    logic [6:0] seg_nxt_c;
    logic       dp_nxt_c;
    logic       unused_hi_c;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Upper nibbles of the result bus carry nothing for the display
    assign unused_hi_c = ^{digit1[7:4], digit0[7:4], count1[7:4], count0[7:4]};

    assign live_c     = '{d1: digit1[3:0], d0: digit0[3:0],
                          c1: count1[3:0], c0: count0[3:0], warn: warning};
    assign boundary_c = (slot == 2'd3) && (div == DIV_LAST);

    // Segment / dp pattern for the slot currently being scanned
    always_comb begin
        nib_c     = 4'h0;
        seg_hi_c  = 7'h00;
        seg_nxt_c = SEG_OFF;
        dp_nxt_c  = DP_OFF;
        case (slot)
            2'd0:    nib_c = display.c0;
            2'd1:    nib_c = display.c1;
            2'd2:    nib_c = display.d0;
            default: nib_c = display.d1;
        endcase
        seg_hi_c = hex7(nib_c);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 2'd1 && display.c1 == 4'h0 && display.c0 != 4'h0) begin
            seg_hi_c = 7'h00;
        end
        if (slot == 2'd3 && display.d1 == 4'h0 && display.d0 != 4'h0) begin
            seg_hi_c = 7'h00;
        end
`endif
        // Warning overrides the digit pair: dash in phase 0, blank in phase 1
        if (display.warn && slot[1]) begin
            seg_hi_c = phase ? 7'h00 : 7'h40;
        end
        seg_nxt_c = SEG_ACTIVE_LOW ? ~seg_hi_c : seg_hi_c;
        dp_nxt_c  = (slot == 2'd2) ^ SEG_ACTIVE_LOW;
    end

    // Scan counters, capture/commit registers and registered outputs
    always_ff @(posedge CLK) begin
        if (clear) begin
            pending    <= '0;
            display    <= '0;
            pend_flag  <= 1'b0;
            div        <= '0;
            slot       <= 2'd0;
            frame      <= '0;
            phase      <= 1'b0;
            an         <= 4'hF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= ~(4'b0001 << slot);
            seg        <= seg_nxt_c;
            dp         <= dp_nxt_c;
            frame_done <= boundary_c;

            if (div == DIV_LAST) begin
                div  <= '0;
                slot <= slot + 2'd1;
            end else begin
                div <= div + DIV_W'(1);
            end

            if (boundary_c) begin
                // A load on the boundary itself bypasses pending
                if (load || pend_flag) begin
                    display <= load ? live_c : pending;
                end
                pend_flag <= 1'b0;
                if (frame == FRM_LAST) begin
                    frame <= '0;
                    phase <= ~phase;
                end else begin
                    frame <= frame + FRM_W'(1);
                end
            end else if (load) begin
                pending   <= live_c;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule
